// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mux4_rr_arbiter                                                 |
// | Desc     : Round-robin scheduler for a shared 4:1 word mux with one       |
// |            valid/ready output slot. Optional MUX4_ARB_LOCK_EN adds the    |
// |            lock port for burst ownership of the slot.                     |
// | Revision : 1.0                                                             |
// +--------------------------------------------------------------------------+
module mux4_rr_arbiter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] D,
  output logic [3:0]     gnt,
  output logic [1:0]     S,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   A
`ifdef MUX4_ARB_LOCK_EN
  ,
  input  logic [3:0]     lock
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   last_q, last_d;
  logic [1:0]   s_q, s_d;
  logic [W-1:0] a_q, a_d;
  logic [3:0]   gnt_q, gnt_d;

  logic [W-1:0] w_words [4];
  logic         w_arb_en;
  logic         w_found;
  logic [1:0]   w_win;
  logic [1:0]   w_cand;

  for (genvar g = 0; g < 4; g++) begin : g_words
    assign w_words[g] = D[g*W +: W];
  end

  // A full slot may only be refilled in the cycle it is being drained.
  assign w_arb_en = (state_q == IDLE) || out_ready;

  always_comb begin
    w_found = 1'b0;
    w_win   = last_q;
    w_cand  = last_q;
    for (int k = 1; k <= 4; k++) begin
      w_cand = last_q + 2'(k);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
`ifdef MUX4_ARB_LOCK_EN
    // A locked current owner keeps the slot at a handshake.
    if ((state_q == BUSY) && lock[last_q] && req[last_q]) begin
      w_found = 1'b1;
      w_win   = last_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    s_d     = s_q;
    a_d     = a_q;
    gnt_d   = 4'b0000;
    if (w_arb_en) begin
      if (w_found) begin
        gnt_d[w_win] = 1'b1;
        s_d          = w_win;
        last_d       = w_win;
        a_d          = w_words[w_win];
        state_d      = BUSY;
      end else if (state_q == BUSY) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      s_q     <= 2'd0;
      a_q     <= '0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      s_q     <= s_d;
      a_q     <= a_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign S         = s_q;
  assign A         = a_q;
  assign out_valid = (state_q == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mux4_rr_arbiter                                              |
// | Desc     : Directed, table-driven self-checking bench for mux4_rr_arbiter.|
// |            Define MUX4_ARB_LOCK_EN to also exercise the lock port.        |
// | Revision : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mux4_rr_arbiter;

  localparam int W = 8;
  localparam logic [31:0] C_WORDS = 32'h3CA5_2110;  // w3=3C w2=A5 w1=21 w0=10

  logic           clk;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] D;
  logic [3:0]     gnt;
  logic [1:0]     S;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   A;
`ifdef MUX4_ARB_LOCK_EN
  logic [3:0]     lock;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mux4_rr_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .D         (D),
    .gnt       (gnt),
    .S         (S),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A)
`ifdef MUX4_ARB_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       v;
    logic [7:0] a;
  } vec_t;

  vec_t vecs [21];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                       input logic ev, input logic [7:0] ea);
    n_cmp++;
    if (gnt !== eg || S !== es || out_valid !== ev || A !== ea) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b S=%0d valid=%b A=%h, want gnt=%b S=%0d valid=%b A=%h",
               name, gnt, S, out_valid, A, eg, es, ev, ea);
    end
  endtask

  initial begin
    // {req, ready} -> {gnt, S, out_valid, A} after the next edge; starts IDLE, last=3
    vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00};
    vecs[1]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5};
    vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 8'hA5};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 8'h3C};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h10};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h21};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5};
    vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 8'h3C};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h10};
    vecs[9]  = '{4'b0011, 1'b0, 4'b0000, 2'd0, 1'b1, 8'h10};
    vecs[10] = '{4'b0011, 1'b0, 4'b0000, 2'd0, 1'b1, 8'h10};
    vecs[11] = '{4'b0011, 1'b0, 4'b0000, 2'd0, 1'b1, 8'h10};
    vecs[12] = '{4'b0011, 1'b0, 4'b0000, 2'd0, 1'b1, 8'h10};
    vecs[13] = '{4'b0011, 1'b0, 4'b0000, 2'd0, 1'b1, 8'h10};
    vecs[14] = '{4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h21};
    vecs[15] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1, 8'h21};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 8'h21};
    vecs[17] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 8'h21};
    vecs[18] = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h21};
    vecs[19] = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h21};
    vecs[20] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 8'h21};

    rst_n     = 1'b0;
    req       = 4'($urandom);
    D         = $urandom;
    out_ready = 1'($urandom);
`ifdef MUX4_ARB_LOCK_EN
    lock      = 4'b0000;
`endif
    #2;
    check("reset_async", 4'b0000, 2'd0, 1'b0, 8'h00);
    step();
    req = 4'($urandom);
    D   = $urandom;
    step();
    check("reset_held", 4'b0000, 2'd0, 1'b0, 8'h00);

    D     = C_WORDS;
    req   = 4'b0000;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      req       = vecs[i].req;
      out_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].s, vecs[i].v, vecs[i].a);
    end

    // Reset while the slot is full and stalled: state IDLE, last=1 -> winner 2
    req       = 4'b1111;
    out_ready = 1'b0;
    step();
    check("pre_rst_win", 4'b0100, 2'd2, 1'b1, 8'hA5);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_async", 4'b0000, 2'd0, 1'b0, 8'h00);
    step();
    check("mid_rst_held", 4'b0000, 2'd0, 1'b0, 8'h00);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_first", 4'b0001, 2'd0, 1'b1, 8'h10);
    step();
    check("post_rst_next", 4'b0010, 2'd1, 1'b1, 8'h21);

`ifdef MUX4_ARB_LOCK_EN
    #3;
    rst_n = 1'b0;
    #1;
    req   = 4'b0011;
    lock  = 4'b0001;
    step();
    rst_n = 1'b1;
    step();
    check("lock_beat0", 4'b0001, 2'd0, 1'b1, 8'h10);
    step();
    check("lock_beat1", 4'b0001, 2'd0, 1'b1, 8'h10);
    step();
    check("lock_beat2", 4'b0001, 2'd0, 1'b1, 8'h10);
    lock = 4'b0000;
    step();
    check("lock_release", 4'b0010, 2'd1, 1'b1, 8'h21);
`endif

    req = 4'b0000;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
